// File: rtl/prga_fifo_wr_arbiter_if.sv
// Source-side lookahead-FIFO read bundle plus shared-FIFO write port.
// Master modport is the arbiter; slave modport is the FIFOs around it.
interface prga_fifo_wr_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_SRC-1:0]            src_empty;
    logic [NUM_SRC-1:0]            src_rd;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_dout;
    logic                          full;
    logic                          wr;
    logic [DATA_WIDTH-1:0]         din;

    modport master (
        input  src_empty,
        input  src_dout,
        input  full,
        output src_rd,
        output wr,
        output din
    );

    modport slave (
        output src_empty,
        output src_dout,
        output full,
        input  src_rd,
        input  wr,
        input  din
    );
endinterface

// File: rtl/prga_fifo_wr_arbiter.sv
// Round-robin burst arbiter merging NUM_SRC lookahead FIFOs onto one FIFO write port.
// Latency: request to first write is one cycle; full stalls the grant indefinitely.
// Backpressure: full gates wr/src_rd combinationally, burst count and grant are held.
module prga_fifo_wr_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    prga_fifo_wr_arbiter_if.master     bus,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy
);
    localparam int GW = $clog2(NUM_SRC);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                r_state;
    logic [GW-1:0]         r_grant_id;
    logic [GW-1:0]         r_last;
    logic [BW-1:0]         r_burst_cnt;

    logic                  w_arb_vld;
    logic [GW-1:0]         w_arb_id;
    int                    w_scan;
    logic                  w_sel_empty;
    logic [DATA_WIDTH-1:0] w_sel_dout;
    logic                  w_in_grant;
    logic                  w_xfer;
    logic                  w_release;
    logic [NUM_SRC-1:0]    w_src_rd;

    // Scan starts one past the last winner, so the current holder ranks last.
    always_comb begin
        w_arb_vld = 1'b0;
        w_arb_id  = '0;
        w_scan    = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_scan = (int'(r_last) + k) % NUM_SRC;
            if (!w_arb_vld && !bus.src_empty[w_scan]) begin
                w_arb_vld = 1'b1;
                w_arb_id  = GW'(w_scan);
            end
        end
    end

    always_comb begin
        w_sel_empty = 1'b1;
        w_sel_dout  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant_id == GW'(i)) begin
                w_sel_empty = bus.src_empty[i];
                w_sel_dout  = bus.src_dout[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_in_grant = rst && (r_state == S_GRANT);
    assign w_xfer     = w_in_grant && !w_sel_empty && !bus.full;
    assign w_release  = w_sel_empty || (w_xfer && (r_burst_cnt == BW'(MAX_BURST - 1)));

    always_comb begin
        w_src_rd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_src_rd[i] = w_xfer && (r_grant_id == GW'(i));
        end
    end

    assign bus.src_rd = w_src_rd;
    assign bus.wr     = w_xfer;
    assign bus.din    = w_in_grant ? w_sel_dout : '0;
    assign grant_id   = r_grant_id;
    assign busy       = (r_state == S_GRANT);

    // On a last-word release the scan sees pre-pop empties; a stale re-grant self-corrects next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_grant_id  <= '0;
            r_last      <= GW'(NUM_SRC - 1);
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_arb_vld) begin
                        r_state     <= S_GRANT;
                        r_grant_id  <= w_arb_id;
                        r_last      <= w_arb_id;
                        r_burst_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        if (w_arb_vld) begin
                            r_grant_id  <= w_arb_id;
                            r_last      <= w_arb_id;
                            r_burst_cnt <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_xfer) begin
                        r_burst_cnt <= r_burst_cnt + BW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prga_fifo_wr_arbiter.sv
// Drives two arbiters (4 src/burst 4 and 3 src/burst 1) from queue-backed sources
// and compares every output each cycle against a burst-level round-robin model.
module tb_prga_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    prga_fifo_wr_arbiter_if #(.NUM_SRC(4), .DATA_WIDTH(8)) bus_a ();
    prga_fifo_wr_arbiter_if #(.NUM_SRC(3), .DATA_WIDTH(8)) bus_b ();
    logic [1:0] gid_a, gid_b;
    logic       busy_a, busy_b;

    prga_fifo_wr_arbiter #(.NUM_SRC(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.master), .grant_id(gid_a), .busy(busy_a));
    prga_fifo_wr_arbiter #(.NUM_SRC(3), .DATA_WIDTH(8), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.master), .grant_id(gid_b), .busy(busy_b));

    // Source FIFO contents: entries 0..3 feed dut_a, 4..6 feed dut_b.
    logic [7:0] q [8][$];
    int ns [2] = '{4, 3};
    int mb [2] = '{4, 1};
    logic       rst_v;
    logic       full_v [2];

    // Model: whether a source holds the grant, who, the previous winner, words sent this burst.
    bit m_busy [2];
    int m_g    [2];
    int m_last [2];
    int m_sent [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] head(input int j);
        return (q[j].size() != 0) ? q[j][0] : 8'h00;
    endfunction

    function automatic int pick(input int k, input int last);
        for (int s = 1; s <= ns[k]; s++) begin
            if (q[k*4 + (last + s) % ns[k]].size() != 0) return (last + s) % ns[k];
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_g[k]    = 0;
            m_last[k] = ns[k] - 1;
            m_sent[k] = 0;
        end
    endtask

    task automatic drive();
        rst        = rst_v;
        bus_a.full = full_v[0];
        bus_b.full = full_v[1];
        for (int i = 0; i < 4; i++) begin
            bus_a.src_empty[i]       = (q[i].size() == 0);
            bus_a.src_dout[i*8 +: 8] = head(i);
        end
        for (int i = 0; i < 3; i++) begin
            bus_b.src_empty[i]       = (q[4+i].size() == 0);
            bus_b.src_dout[i*8 +: 8] = head(4 + i);
        end
    endtask

    // One clock: drive at negedge, compare mid-cycle, advance model, pop what the DUT read.
    task automatic step();
        logic [3:0] o_rd [2];
        logic       o_wr [2];
        logic [7:0] o_din [2];
        logic [1:0] o_gid [2];
        logic       o_busy [2];
        @(negedge clk);
        drive();
        #1;
        o_rd[0] = bus_a.src_rd;         o_rd[1] = {1'b0, bus_b.src_rd};
        o_wr[0] = bus_a.wr;             o_wr[1] = bus_b.wr;
        o_din[0] = bus_a.din;           o_din[1] = bus_b.din;
        o_gid[0] = gid_a;               o_gid[1] = gid_b;
        o_busy[0] = busy_a;             o_busy[1] = busy_b;
        for (int k = 0; k < 2; k++) begin
            string p;
            bit    act, ne, x;
            int    w;
            p   = (k == 0) ? "A" : "B";
            ne  = (q[k*4 + m_g[k]].size() != 0);
            act = rst_v && m_busy[k];
            x   = act && ne && !full_v[k];
            check({p, ".wr"},       32'(o_wr[k]),   32'(x));
            check({p, ".src_rd"},   32'(o_rd[k]),   x ? (32'd1 << m_g[k]) : 32'd0);
            check({p, ".din"},      32'(o_din[k]),  act ? 32'(head(k*4 + m_g[k])) : 32'd0);
            check({p, ".grant_id"}, 32'(o_gid[k]),  32'(m_g[k]));
            check({p, ".busy"},     32'(o_busy[k]), 32'(m_busy[k]));
            if (!rst_v) begin
                m_busy[k] = 1'b0;
                m_g[k]    = 0;
                m_last[k] = ns[k] - 1;
                m_sent[k] = 0;
            end else if (!m_busy[k] || !ne || (x && m_sent[k] + 1 == mb[k])) begin
                w = pick(k, m_last[k]);
                if (w >= 0) begin
                    m_busy[k] = 1'b1;
                    m_g[k]    = w;
                    m_last[k] = w;
                    m_sent[k] = 0;
                end else begin
                    m_busy[k] = 1'b0;
                end
            end else if (x) begin
                m_sent[k]++;
            end
            for (int i = 0; i < ns[k]; i++) begin
                if (o_rd[k][i] && q[k*4 + i].size() != 0) void'(q[k*4 + i].pop_front());
            end
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        logic [7:0] single [6];
        single = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2};
        rst_v = 1'b0;
        full_v[0] = 1'b0;
        full_v[1] = 1'b0;
        drive();
        @(posedge clk);
        model_reset();

        // Reset held with every source loaded, then released.
        for (int j = 0; j < 8; j++) q[j].push_back(8'(8'h10 + j));
        run(2);
        rst_v = 1'b1;
        run(10);

        // Single source 2, six words.
        foreach (single[i]) q[2].push_back(single[i]);
        run(12);

        // All four sources with eight words each.
        for (int i = 0; i < 4; i++)
            for (int w = 0; w < 8; w++) q[i].push_back(8'((i << 4) | w));
        run(40);

        // Backpressure: source 1 alone, full for 5 cycles after its second word.
        for (int w = 0; w < 4; w++) q[1].push_back(8'(8'hB0 + w));
        for (int c = 0; c < 14; c++) begin
            full_v[0] = (c >= 3 && c < 8);
            step();
        end
        full_v[0] = 1'b0;

        // Burst of one on the 3-source arbiter: sources 0 and 2 alternate.
        for (int w = 0; w < 4; w++) begin
            q[4].push_back(8'(8'hC0 + w));
            q[6].push_back(8'(8'hE0 + w));
        end
        run(14);

        // Reset during source 3's second word on dut_a, source 0 waiting too.
        for (int w = 0; w < 4; w++) q[3].push_back(8'(8'hD0 + w));
        run(2);
        q[0].push_back(8'h77);
        rst_v = 1'b0;
        step();
        rst_v = 1'b1;
        run(12);

        // Random traffic, random full, occasional reset.
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < 7; j++)
                if ($urandom_range(99) < 30 && q[j].size() < 12) q[j].push_back(8'($urandom));
            full_v[0] = ($urandom_range(99) < 25);
            full_v[1] = ($urandom_range(99) < 25);
            rst_v     = ($urandom_range(99) >= 2);
            step();
        end
        rst_v = 1'b1;
        full_v[0] = 1'b0;
        full_v[1] = 1'b0;
        run(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
